// File: rtl/keypad_pkg.sv
// Shared types and the hex keymap for the matrix keypad scanner.
// map_code turns a scan index (c*4 + r) into the digit code delivered downstream.
package keypad_pkg;

  typedef enum logic [1:0] {
    DRIVE = 2'b00,
    EVAL  = 2'b01
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    KEY   = 2'b01,
    MULTI = 2'b10
  } scan_t;

  // Entry [c*4 + r]: c0 = A,3,2,1  c1 = B,6,5,4  c2 = C,9,8,7  c3 = D,E,0,F
  localparam logic [15:0][3:0] HEX_KEYMAP = {
    4'hF, 4'h0, 4'hE, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h1, 4'h2, 4'h3, 4'hA
  };

  function automatic logic [31:0] map_code(input logic [31:0] index, input logic hex_map);
    if (hex_map) begin
      return {28'd0, HEX_KEYMAP[index[3:0]]};
    end
    return index;
  endfunction

endpackage

// File: rtl/keypad_scanner_gen_debounce.sv
// Scan-to-scan debounce tracker: counts identical consecutive scans and fires a
// single press per closure; a latched key must see DEBOUNCE empty scans to re-arm.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int IDX_W    = 4
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             scan_valid,
  input  scan_t            scan_class,
  input  logic [IDX_W-1:0] scan_index,
  output logic             press
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  scan_t            prev_class_reg, prev_class_next;
  logic [IDX_W-1:0] prev_index_reg, prev_index_next;
  logic [CNT_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic             latched_reg, latched_next;
  logic [CNT_W-1:0] cnt_upd;
  logic             reached;

  always_ff @(posedge Clock) begin
    if (reset) begin
      prev_class_reg <= NONE;
      prev_index_reg <= '0;
      stable_cnt_reg <= '0;
      latched_reg    <= 1'b0;
    end else begin
      prev_class_reg <= prev_class_next;
      prev_index_reg <= prev_index_next;
      stable_cnt_reg <= stable_cnt_next;
      latched_reg    <= latched_next;
    end
  end

  always_comb begin
    prev_class_next = prev_class_reg;
    prev_index_next = prev_index_reg;
    stable_cnt_next = stable_cnt_reg;
    latched_next    = latched_reg;
    press           = 1'b0;
    // Saturate so a long hold cannot wrap back through DEBOUNCE.
    if ((scan_class == prev_class_reg) && (scan_index == prev_index_reg)) begin
      cnt_upd = (stable_cnt_reg == CNT_W'(DEBOUNCE)) ? stable_cnt_reg : stable_cnt_reg + 1'b1;
    end else begin
      cnt_upd = CNT_W'(1);
    end
    reached = (cnt_upd == CNT_W'(DEBOUNCE));
    if (scan_valid) begin
      prev_class_next = scan_class;
      prev_index_next = scan_index;
      stable_cnt_next = cnt_upd;
      if (!latched_reg && (scan_class == KEY) && reached) begin
        press        = 1'b1;
        latched_next = 1'b1;
      end else if (latched_reg && (scan_class == NONE) && reached) begin
        latched_next = 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner_gen.sv
// Matrix keypad scanner: open-drain column drive, settled row sampling, ghost
// rejection, one-shot key reporting on valid/ready and operand assembly.
module keypad_scanner_gen
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE     = 2,
  parameter int DEBOUNCE   = 3,
  parameter int DIGITS     = 4,
  parameter int HEX_MAP    = 1,
  parameter int SHIFT_MODE = 0,
  localparam int NKEYS     = ROWS * COLS,
  localparam int IDX_W     = (NKEYS > 1) ? $clog2(NKEYS) : 1,
  localparam int CODE_W    = (IDX_W > 4) ? IDX_W : 4,
  localparam int DCNT_W    = $clog2(DIGITS + 1),
  localparam int MEM_W     = DIGITS * CODE_W
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   RowIn,
  output logic [COLS-1:0]   ColOut,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key_code,
  input  logic              clear,
  output logic [MEM_W-1:0]  mem_reg,
  output logic [DCNT_W-1:0] digit_count,
  output logic              multi_key,
  output logic              overrun
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t             state_reg, state_next;
  logic [COL_W-1:0]   col_idx_reg, col_idx_next;
  logic [SET_W-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [NKEYS-1:0]   snapshot_reg, snapshot_next;
  logic               run_reg;
  logic               eval_now;

  scan_t              scan_class;
  logic [IDX_W-1:0]   scan_index;
  logic [IDX_W-1:0]   hit_idx;
  int                 zeros;
  logic               press;

  logic               key_valid_reg, key_valid_next;
  logic [CODE_W-1:0]  key_code_reg, key_code_next;
  logic [MEM_W-1:0]   mem_value_reg, mem_value_next;
  logic [DCNT_W-1:0]  digit_count_reg, digit_count_next;
  logic               multi_key_reg, multi_key_next;
  logic               overrun_reg, overrun_next;
  logic               accept;
  logic [CODE_W-1:0]  code_new;
  int                 slot_pos;

  // run_reg keeps every column released until the first cycle out of reset.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_reg      <= DRIVE;
      col_idx_reg    <= '0;
      settle_cnt_reg <= '0;
      snapshot_reg   <= '1;
      run_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_idx_reg    <= col_idx_next;
      settle_cnt_reg <= settle_cnt_next;
      snapshot_reg   <= snapshot_next;
      run_reg        <= 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    col_idx_next    = col_idx_reg;
    settle_cnt_next = settle_cnt_reg;
    snapshot_next   = snapshot_reg;
    eval_now        = 1'b0;
    if (run_reg) begin
      case (state_reg)
        DRIVE: begin
          if (settle_cnt_reg == SET_W'(SETTLE - 1)) begin
            snapshot_next[int'(col_idx_reg) * ROWS +: ROWS] = RowIn;
            settle_cnt_next = '0;
            if (col_idx_reg == COL_W'(COLS - 1)) begin
              col_idx_next = '0;
              state_next   = EVAL;
            end else begin
              col_idx_next = col_idx_reg + 1'b1;
            end
          end else begin
            settle_cnt_next = settle_cnt_reg + 1'b1;
          end
        end
        EVAL: begin
          eval_now        = 1'b1;
          state_next      = DRIVE;
          col_idx_next    = '0;
          settle_cnt_next = '0;
        end
        default: begin
          state_next      = DRIVE;
          col_idx_next    = '0;
          settle_cnt_next = '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign ColOut[gi] = (run_reg && (state_reg == DRIVE) && (col_idx_reg == COL_W'(gi))) ? 1'b0 : 1'bz;
  end

  always_comb begin
    zeros   = 0;
    hit_idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (!snapshot_reg[i]) begin
        zeros   = zeros + 1;
        hit_idx = IDX_W'(i);
      end
    end
    if (zeros == 0) begin
      scan_class = NONE;
    end else if (zeros == 1) begin
      scan_class = KEY;
    end else begin
      scan_class = MULTI;
    end
    // Non-KEY scans carry index 0 so the tracker compares them consistently.
    scan_index = (scan_class == KEY) ? hit_idx : '0;
  end

  keypad_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .IDX_W    (IDX_W)
  ) u_debounce (
    .Clock      (Clock),
    .reset      (reset),
    .scan_valid (eval_now),
    .scan_class (scan_class),
    .scan_index (scan_index),
    .press      (press)
  );

  assign accept   = key_valid_reg & key_ready;
  assign code_new = CODE_W'(map_code(32'(scan_index), HEX_MAP != 0));

  always_ff @(posedge Clock) begin
    if (reset) begin
      key_valid_reg   <= 1'b0;
      key_code_reg    <= '0;
      mem_value_reg   <= '0;
      digit_count_reg <= '0;
      multi_key_reg   <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      key_valid_reg   <= key_valid_next;
      key_code_reg    <= key_code_next;
      mem_value_reg   <= mem_value_next;
      digit_count_reg <= digit_count_next;
      multi_key_reg   <= multi_key_next;
      overrun_reg     <= overrun_next;
    end
  end

  always_comb begin
    key_valid_next   = key_valid_reg & ~accept;
    key_code_next    = key_code_reg;
    mem_value_next   = mem_value_reg;
    digit_count_next = digit_count_reg;
    multi_key_next   = eval_now && (scan_class == MULTI);
    overrun_next     = 1'b0;
    // Slot 0 is the most significant digit; a saturated count wraps to slot 0.
    slot_pos = (digit_count_reg == DCNT_W'(DIGITS)) ? (DIGITS - 1) : (DIGITS - 1 - int'(digit_count_reg));
    if (press) begin
      if (!key_valid_reg || accept) begin
        key_code_next  = code_new;
        key_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
    if (clear) begin
      mem_value_next   = '0;
      digit_count_next = '0;
    end else if (accept) begin
      if (SHIFT_MODE != 0) begin
        mem_value_next = (mem_value_reg << CODE_W) | MEM_W'(key_code_reg);
      end else begin
        mem_value_next[slot_pos * CODE_W +: CODE_W] = key_code_reg;
      end
      if (digit_count_reg != DCNT_W'(DIGITS)) begin
        digit_count_next = digit_count_reg + 1'b1;
      end
    end
  end

  assign key_valid   = key_valid_reg;
  assign key_code    = key_code_reg;
  assign mem_reg     = mem_value_reg;
  assign digit_count = digit_count_reg;
  assign multi_key   = multi_key_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_keypad_scanner_gen.sv
// Bench for keypad_scanner_gen: a keypad model closes switches between columns and
// rows; two DUTs (positional and shift-left entry) run in lock-step off one keypad.
module tb_keypad_scanner_gen;

  localparam int SCAN = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_ready = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] closed = '0;

  wire  [3:0]  col_out0, col_out1;
  logic [3:0]  row_in0, row_in1;
  logic        key_valid0, key_valid1, multi_key0, multi_key1, overrun0, overrun1;
  logic [3:0]  key_code0, key_code1;
  logic [15:0] mem0, mem1;
  logic [2:0]  digit_count0, digit_count1;

  pullup (col_out0);
  pullup (col_out1);

  always #5 clk = ~clk;

  keypad_scanner_gen #(.SHIFT_MODE(0)) dut0 (
    .Clock(clk), .reset(reset), .RowIn(row_in0), .ColOut(col_out0),
    .key_valid(key_valid0), .key_ready(key_ready), .key_code(key_code0),
    .clear(clear), .mem_reg(mem0), .digit_count(digit_count0),
    .multi_key(multi_key0), .overrun(overrun0)
  );

  keypad_scanner_gen #(.SHIFT_MODE(1)) dut1 (
    .Clock(clk), .reset(reset), .RowIn(row_in1), .ColOut(col_out1),
    .key_valid(key_valid1), .key_ready(key_ready), .key_code(key_code1),
    .clear(clear), .mem_reg(mem1), .digit_count(digit_count1),
    .multi_key(multi_key1), .overrun(overrun1)
  );

  // Closed switch (c,r) pulls row r low while column c is driven.
  always_comb begin
    row_in0 = 4'hF;
    row_in1 = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (closed[c*4+r] && (col_out0[c] == 1'b0)) row_in0[r] = 1'b0;
        if (closed[c*4+r] && (col_out1[c] == 1'b0)) row_in1[r] = 1'b0;
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int rise_cycle = 0;
  int multi_cnt = 0;
  int overrun_cnt = 0;
  logic kv_prev = 1'b0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted key is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (key_valid0 && !kv_prev) begin
        rise_cnt++;
        rise_cycle = cyc;
      end
      multi_cnt += int'(multi_key0);
      overrun_cnt += int'(overrun0);
      if (key_valid0 && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got key %0h expected no accept", key_code0);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("sb_code_dut0", {28'd0, key_code0}, {28'd0, e});
          check("sb_code_dut1", {28'd0, key_code1}, {28'd0, e});
        end
      end
    end
    kv_prev = key_valid0;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input int idx, input int hold_scans, input int rel_scans);
    closed[idx] = 1'b1;
    wait_cycles(hold_scans * SCAN);
    closed[idx] = 1'b0;
    wait_cycles(rel_scans * SCAN);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    wait_cycles(1);
    clear = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!key_valid0 && n < 100) begin
      wait_cycles(1);
      n++;
    end
    checks++;
    if (!key_valid0) begin
      failures++;
      $display("FAIL %s: got no key_valid within %0d cycles expected key_valid=1", name, n);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_colout0"}, {28'd0, col_out0}, 32'hF);
    check({tag, "_colout1"}, {28'd0, col_out1}, 32'hF);
    check({tag, "_valid"}, {31'd0, key_valid0}, 32'd0);
    check({tag, "_code"}, {28'd0, key_code0}, 32'd0);
    check({tag, "_mem0"}, {16'd0, mem0}, 32'd0);
    check({tag, "_mem1"}, {16'd0, mem1}, 32'd0);
    check({tag, "_count"}, {29'd0, digit_count0}, 32'd0);
    check({tag, "_multi"}, {31'd0, multi_key0}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun0}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2, lat, t0, n;

    // Reset state and first column drive after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("colout_idle_before_start", {28'd0, col_out0}, 32'hF);
    @(posedge clk);
    @(negedge clk);
    check("colout_col0_first", {28'd0, col_out0}, 32'hE);
    @(posedge clk);
    #1;

    // Single key '1' (col 0, row 3) held long: reported once.
    key_ready = 1'b1;
    exp_q.push_back(4'h1);
    closed[3] = 1'b1;
    wait_cycles(7 * SCAN);
    check("hold_single_report", rise_cnt, 1);
    check("t1_mem0", {16'd0, mem0}, 32'h1000);
    check("t1_mem1", {16'd0, mem1}, 32'h0001);
    check("t1_count", {29'd0, digit_count0}, 32'd1);
    closed[3] = 1'b0;
    wait_cycles(5 * SCAN);

    // Digits 1..5: positional wraps into slot 0, shift mode keeps the last four.
    pulse_clear();
    check("clear_count", {29'd0, digit_count0}, 32'd0);
    base = rise_cnt;
    exp_q.push_back(4'h1); press_release(3, 5, 5);
    exp_q.push_back(4'h2); press_release(2, 5, 5);
    exp_q.push_back(4'h3); press_release(1, 5, 5);
    exp_q.push_back(4'h4); press_release(7, 5, 5);
    exp_q.push_back(4'h5); press_release(6, 5, 5);
    check("seq_reports", rise_cnt - base, 5);
    check("seq_mem_pos", {16'd0, mem0}, 32'h5234);
    check("seq_mem_shift", {16'd0, mem1}, 32'h2345);
    check("seq_count_pos", {29'd0, digit_count0}, 32'd4);
    check("seq_count_shift", {29'd0, digit_count1}, 32'd4);

    // Ghost: rows 0 and 1 closed in column 2.
    base = rise_cnt;
    closed[8] = 1'b1;
    closed[9] = 1'b1;
    wait_cycles(2 * SCAN);
    base2 = multi_cnt;
    wait_cycles(5 * SCAN);
    check("multi_per_scan", multi_cnt - base2, 5);
    check("multi_no_report", rise_cnt - base, 0);
    check("multi_not_latched", {31'd0, dut0.u_debounce.latched_reg}, 32'd0);
    closed[8] = 1'b0;
    closed[9] = 1'b0;
    wait_cycles(5 * SCAN);

    // Bounce on '6' every scan, then stable.
    base = rise_cnt;
    exp_q.push_back(4'h6);
    closed[5] = 1'b1; wait_cycles(SCAN);
    closed[5] = 1'b0; wait_cycles(SCAN);
    closed[5] = 1'b1; wait_cycles(SCAN);
    closed[5] = 1'b0; wait_cycles(SCAN);
    closed[5] = 1'b1;
    t0 = cyc;
    wait_cycles(6 * SCAN);
    check("bounce_one_report", rise_cnt - base, 1);
    lat = rise_cycle - t0;
    checks++;
    if (lat < 2 * SCAN || lat > 5 * SCAN) begin
      failures++;
      $display("FAIL bounce_latency: got %0d cycles expected 18..45", lat);
    end
    closed[5] = 1'b0;
    wait_cycles(5 * SCAN);

    // Overrun: 7 pending, 8 dropped.
    pulse_clear();
    key_ready = 1'b0;
    base = overrun_cnt;
    exp_q.push_back(4'h7);
    press_release(11, 5, 5);
    press_release(10, 5, 5);
    check("ovr_code_held", {28'd0, key_code0}, 32'h7);
    check("ovr_valid_held", {31'd0, key_valid0}, 32'd1);
    check("ovr_pulse_once", overrun_cnt - base, 1);
    key_ready = 1'b1;
    wait_cycles(3);
    check("ovr_mem_top", {28'd0, mem0[15:12]}, 32'h7);
    check("ovr_mem_shift", {16'd0, mem1}, 32'h0007);

    // clear in the same cycle as accepting '9'.
    key_ready = 1'b0;
    exp_q.push_back(4'h9);
    closed[9] = 1'b1;
    wait_valid("clr_wait_valid");
    key_ready = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    key_ready = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    check("clr_valid", {31'd0, key_valid0}, 32'd0);
    check("clr_mem0", {16'd0, mem0}, 32'd0);
    check("clr_mem1", {16'd0, mem1}, 32'd0);
    check("clr_count", {29'd0, digit_count0}, 32'd0);
    @(posedge clk);
    #1;
    closed[9] = 1'b0;
    wait_cycles(5 * SCAN);

    // Reset mid-DRIVE of column 2 with a key pending.
    key_ready = 1'b1;
    exp_q.push_back(4'hA);
    press_release(0, 5, 5);
    check("pre_reset_mem", {16'd0, mem0}, 32'hA000);
    key_ready = 1'b0;
    closed[4] = 1'b1;
    wait_valid("rst_wait_valid");
    n = 0;
    while (col_out0 != 4'hB && n < 20) begin
      wait_cycles(1);
      n++;
    end
    check("rst_col2_reached", {28'd0, col_out0}, 32'hB);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midscan_reset");
    closed[4] = 1'b0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(5 * SCAN);
    check("post_reset_no_key", {31'd0, key_valid0}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
